// File: rtl/rede_feeder.sv
// Sample FIFO feeding the `in` port of the rede network; pops one sample per request code.
// Optional build macro FEEDER_ZERO_FILL_EN: an empty-FIFO request returns a zero sample instead of stalling.
module rede_feeder #(
  parameter int          DATA_W   = 31,
  parameter int          DEPTH    = 16,
  parameter int          AW       = 4,
  parameter logic [3:0]  REQ_CODE = 4'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     full,
  output logic [AW:0]              level,
  input  logic [3:0]               req_in,
  output logic signed [DATA_W-1:0] in_data,
  output logic                     in_valid,
  output logic                     starved,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_STARVED
  } state_e;

  state_e                     state_q;
  logic signed [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]              wr_ptr_q;
  logic [AW-1:0]              rd_ptr_q;
  logic [AW:0]                level_q;
  logic [AW:0]                level_d;
  logic signed [DATA_W-1:0]   in_data_q;
  logic                       in_valid_q;
  logic                       starved_q;
  logic                       overflow_q;
  logic                       underflow_q;

  logic req;
  logic empty;
  logic is_full;
  logic pop;
  logic push;
  logic drop;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    req     = (req_in == REQ_CODE);
    empty   = (level_q == '0);
    is_full = (level_q == DEPTH_CNT);
    pop     = 1'b0;
    if (!empty) begin
      if (state_q == S_STARVED) pop = 1'b1;
      else if (req)             pop = 1'b1;
    end
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push    = wr_en && (!is_full || pop);
    drop    = wr_en && !push;
    level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  // NOTE: sample storage is deliberately not reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      starved_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      level_q    <= level_d;

      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (drop) overflow_q <= 1'b1;

      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        in_data_q  <= mem_q[rd_ptr_q];
        in_valid_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (req && empty) begin
            underflow_q <= 1'b1;
`ifdef FEEDER_ZERO_FILL_EN
            in_data_q   <= '0;
            in_valid_q  <= 1'b1;
`else
            state_q     <= S_STARVED;
            starved_q   <= 1'b1;
`endif
          end
        end
        S_STARVED: begin
          // Further requests while starved are absorbed; only one is ever outstanding.
          if (!empty) begin
            state_q   <= S_IDLE;
            starved_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          starved_q <= 1'b0;
        end
      endcase
    end
  end

  assign full      = is_full;
  assign level     = level_q;
  assign in_data   = in_data_q;
  assign in_valid  = in_valid_q;
  assign starved   = starved_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_rede_feeder.sv
// Self-checking bench for rede_feeder: queue-based reference model compared every cycle,
// plus directed literal expectations for each scenario.
module tb_rede_feeder;

  localparam int DATA_W = 31;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr_en;
  logic signed [DATA_W-1:0] wr_data;
  logic                     full;
  logic [AW:0]              level;
  logic [3:0]               req_in;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     starved;
  logic                     overflow;
  logic                     underflow;

  rede_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .req_in    (req_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .starved   (starved),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    else
      n_passed++;
  endtask

  // Reference model: a plain queue of samples and one pending-request flag.
  int mq[$];
  bit m_ready = 1'b0;
  bit m_pend;
  int m_data;
  bit m_valid;
  bit m_ovf;
  bit m_unf;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_pend  = 1'b0;
      m_data  = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      bit popped;
      popped  = 1'b0;
      m_valid = 1'b0;
      if (!m_pend && req_in == 4'd1) begin
        if (mq.size() > 0) begin
          m_data  = mq.pop_front();
          m_valid = 1'b1;
          popped  = 1'b1;
        end else begin
          m_unf = 1'b1;
`ifdef FEEDER_ZERO_FILL_EN
          m_data  = 0;
          m_valid = 1'b1;
`else
          m_pend  = 1'b1;
`endif
        end
      end else if (m_pend && mq.size() > 0) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
        m_pend  = 1'b0;
        popped  = 1'b1;
      end
      if (wr_en) begin
        if (mq.size() < DEPTH || popped) mq.push_back(int'(wr_data));
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("m_level",     level,     mq.size());
      check("m_full",      full,      (mq.size() == DEPTH) ? 1 : 0);
      check("m_in_valid",  in_valid,  m_valid);
      check("m_in_data",   in_data,   m_data);
      check("m_starved",   starved,   m_pend);
      check("m_overflow",  overflow,  m_ovf);
      check("m_underflow", underflow, m_unf);
    end
  end

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
  endtask

  initial begin
    int t1[3];
    t1 = '{5, -7, 1073741823};
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; req_in = 4'd0;
    cyc(2);
    check("rst_level", level, 0);
    check("rst_valid", in_valid, 0);
    check("rst_data",  in_data, 0);
    rst = 1'b1;

    // Three pushes, three spaced single-cycle requests.
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = DATA_W'(t1[i]);
      cyc(1);
    end
    wr_en = 1'b0;
    check("t1_level3", level, 3);
    for (int i = 0; i < 3; i++) begin
      req_in = 4'd1;
      cyc(1);
      req_in = 4'd0;
      check("t1_valid", in_valid, 1);
      check("t1_data", in_data, t1[i]);
      cyc(1);
      check("t1_pulse", in_valid, 0);
      cyc(1);
    end
    check("t1_level0", level, 0);

    // Overfill by one, then drain in order, then wrap pointers.
    wr_en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      wr_data = DATA_W'(i);
      cyc(1);
      if (i == 16) check("t2_full", full, 1);
    end
    wr_en = 1'b0;
    check("t2_level16", level, 16);
    check("t2_overflow", overflow, 1);
    req_in = 4'd1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      check("t2_drain", in_data, i);
    end
    req_in = 4'd0;
    cyc(1);
    check("t2_empty", level, 0);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = DATA_W'(100 + i);
      cyc(1);
      wr_en = 1'b0; req_in = 4'd1;
      cyc(1);
      req_in = 4'd0;
      check("t2_wrap", in_data, 100 + i);
    end

    // Request on an empty FIFO.
    req_in = 4'd1;
    cyc(1);
    req_in = 4'd0;
    check("t3_underflow", underflow, 1);
`ifdef FEEDER_ZERO_FILL_EN
    check("t3_zf_valid", in_valid, 1);
    check("t3_zf_data", in_data, 0);
    check("t3_zf_starved", starved, 0);
`else
    check("t3_starved", starved, 1);
    cyc(2);
    wr_en = 1'b1; wr_data = DATA_W'(-1234);
    cyc(1);
    wr_en = 1'b0;
    check("t3_wait", in_valid, 0);
    cyc(1);
    check("t3_valid", in_valid, 1);
    check("t3_data", in_data, -1234);
    check("t3_unstarved", starved, 0);
`endif

    // Full FIFO with same-cycle push and request.
    do_reset();
    check("t4_ovf_clr", overflow, 0);
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = DATA_W'(200 + i);
      cyc(1);
    end
    wr_data = DATA_W'(99); req_in = 4'd1;
    cyc(1);
    wr_en = 1'b0; req_in = 4'd0;
    check("t4_data", in_data, 200);
    check("t4_level", level, 16);
    check("t4_ovf", overflow, 0);

    // Drain to 3, then non-request codes must be ignored.
    req_in = 4'd1;
    cyc(13);
    req_in = 4'd2;
    check("t5_level3", level, 3);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("t5_novalid", in_valid, 0);
    end
    req_in = 4'd1;
    cyc(3);
    req_in = 4'd0;
    check("t5_last", in_data, 99);
    cyc(1);

    // Request on empty, then reset while the request is pending.
    req_in = 4'd1;
    cyc(1);
    req_in = 4'd0;
`ifndef FEEDER_ZERO_FILL_EN
    check("t6_starved", starved, 1);
`endif
    do_reset();
    check("t6_starved_clr", starved, 0);
    check("t6_level", level, 0);
    wr_en = 1'b1; wr_data = DATA_W'(7);
    cyc(1);
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("t6_novalid", in_valid, 0);
    end
    check("t6_level1", level, 1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
